// File: rtl/timing_pkg.sv
// Shared codes for the 4004 instruction-cycle timing sequencer: subcycle and
// phase-slot encodings plus the hold FSM state type.
package timing_pkg;

  localparam int NUM_SUBCYCLES = 8;

  localparam logic [2:0] SC_A1 = 3'd0;
  localparam logic [2:0] SC_A2 = 3'd1;
  localparam logic [2:0] SC_A3 = 3'd2;
  localparam logic [2:0] SC_M1 = 3'd3;
  localparam logic [2:0] SC_M2 = 3'd4;
  localparam logic [2:0] SC_X1 = 3'd5;
  localparam logic [2:0] SC_X2 = 3'd6;
  localparam logic [2:0] SC_X3 = 3'd7;

  typedef enum logic [1:0] {
    SLOT_CLK1 = 2'd0,
    SLOT_GAP1 = 2'd1,
    SLOT_CLK2 = 2'd2,
    SLOT_GAP2 = 2'd3
  } slot_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HELD = 1'b1
  } hold_state_t;

endpackage

// File: rtl/timing_sequencer_if.sv
// Debug handshake and timing outputs of the sequencer, bundled for the boards
// that consume them.
interface timing_sequencer_if;
  logic       hold;
  logic       step;
  logic       held;
  logic       clk1;
  logic       clk2;
  logic       sync;
  logic       a12, a22, a32, m12, m22, x12, x22, x32;
  logic       x21_clk2;
  logic       x31_clk2;
  logic [2:0] subcycle;

  modport master (
    output hold, step,
    input  held, clk1, clk2, sync,
    input  a12, a22, a32, m12, m22, x12, x22, x32,
    input  x21_clk2, x31_clk2, subcycle
  );

  modport slave (
    input  hold, step,
    output held, clk1, clk2, sync,
    output a12, a22, a32, m12, m22, x12, x22, x32,
    output x21_clk2, x31_clk2, subcycle
  );
endinterface

// File: rtl/phase_divider.sv
// Divides sysclk into the four phase slots of a subcycle; each slot lasts
// PHASE_LEN sysclk. Freezes in place while enable is low.
module phase_divider
  import timing_pkg::*;
#(
  parameter int PHASE_LEN = 2
) (
  input  logic  sysclk,
  input  logic  poc,
  input  logic  enable,
  output slot_t slot,
  output logic  slot_last,
  output logic  sub_tick
);

  logic [3:0] slot_cnt;

  assign slot_last = (slot_cnt == 4'(PHASE_LEN - 1));
  assign sub_tick  = enable && slot_last && (slot == SLOT_GAP2);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sysclk) begin
    if (poc) begin
      slot_cnt <= '0;
      slot     <= SLOT_CLK1;
    end else if (enable) begin
      if (slot_last) begin
        slot_cnt <= '0;
        slot     <= slot_t'(2'(slot + 2'd1));
      end else begin
        slot_cnt <= slot_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/timing_sequencer.sv
// 4004 instruction-cycle timing: subcycle counter, hold/step debug FSM and the
// registered strobe, clock-window, gate and SYNC outputs.
module timing_sequencer
  import timing_pkg::*;
#(
  parameter int PHASE_LEN = 2
) (
  input  logic               sysclk,
  input  logic               poc,
  timing_sequencer_if.slave  bus
);

  hold_state_t state;
  logic        step_pending;
  logic [2:0]  sub;
  slot_t       slot;
  logic        slot_last;
  logic        sub_tick;
  logic [NUM_SUBCYCLES-1:0] strobe;

  logic run;
  logic cycle_end;

  assign run       = (state == ST_RUN);
  assign cycle_end = sub_tick && (sub == SC_X3);

  phase_divider #(.PHASE_LEN(PHASE_LEN)) u_div (
    .sysclk    (sysclk),
    .poc       (poc),
    .enable    (run),
    .slot      (slot),
    .slot_last (slot_last),
    .sub_tick  (sub_tick)
  );

  // Outputs decode the counter state one sysclk late; while HELD they are
  // forced quiet, so the held A1 slot 0 never shows clk1.
  always_ff @(posedge sysclk) begin
    if (poc) begin
      state        <= ST_RUN;
      step_pending <= 1'b0;
      sub          <= SC_A1;
      strobe       <= '0;
      bus.held     <= 1'b0;
      bus.clk1     <= 1'b0;
      bus.clk2     <= 1'b0;
      bus.sync     <= 1'b0;
      bus.x21_clk2 <= 1'b1;
      bus.x31_clk2 <= 1'b1;
      bus.subcycle <= SC_A1;
    end else begin
      if (sub_tick) sub <= sub + 3'd1;

      case (state)
        ST_RUN: begin
          step_pending <= 1'b0;
          if (cycle_end && bus.hold) state <= ST_HELD;
        end
        ST_HELD: begin
          if (step_pending || !bus.hold) begin
            state        <= ST_RUN;
            step_pending <= 1'b0;
          end else begin
            step_pending <= bus.step;
          end
        end
        default: state <= ST_RUN;
      endcase

      strobe       <= (run && slot == SLOT_CLK2 && slot_last) ? (8'b1 << sub) : '0;
      bus.held     <= !run;
      bus.clk1     <= run && (slot == SLOT_CLK1);
      bus.clk2     <= run && (slot == SLOT_CLK2);
      bus.sync     <= run && (sub == SC_X3);
      bus.x21_clk2 <= !(run && sub == SC_X2 && slot == SLOT_CLK2);
      bus.x31_clk2 <= !(run && sub == SC_X3 && slot == SLOT_CLK2);
      bus.subcycle <= sub;
    end
  end

  assign bus.a12 = strobe[SC_A1];
  assign bus.a22 = strobe[SC_A2];
  assign bus.a32 = strobe[SC_A3];
  assign bus.m12 = strobe[SC_M1];
  assign bus.m22 = strobe[SC_M2];
  assign bus.x12 = strobe[SC_X1];
  assign bus.x22 = strobe[SC_X2];
  assign bus.x32 = strobe[SC_X3];

endmodule
